// File: rtl/systolic_skew_feeder.sv
// Operand skew, diagonal finish-wave and result-token generator feeding a SIZE x SIZE output-stationary PE array.
// Lane i appears 1+(SIZE-i) cycles after acceptance; s_ready drops only while tile spacing is enforced or a flush drains.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_last,
  input  logic [SIZE*DATA_WIDTH-1:0] s_a,
  input  logic [SIZE*DATA_WIDTH-1:0] s_b,
  input  logic                       flush,
  output logic [SIZE*DATA_WIDTH-1:0] in_left,
  output logic [SIZE*DATA_WIDTH-1:0] in_up,
  output logic [SIZE*SIZE-1:0]       finish,
  output logic                       res_valid,
  output logic                       busy
);

  localparam int L  = 2*SIZE - 1;
  localparam int TW = 2*SIZE;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] CYC_MAX = CW'(L - 1);

  typedef enum logic [1:0] {IDLE, ACC, BOUND, DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cyc;
  logic [L-1:0]    r_fin;
  logic [TW-1:0]   r_tok;
  logic            w_ready;
  logic            w_acc;
  logic            w_ts;
  logic            w_launch;
  logic            w_spaced;

  assign w_spaced = (r_cyc == CYC_MAX);
  assign w_ready  = (r_state == IDLE) || (r_state == ACC) || ((r_state == BOUND) && w_spaced);
  assign s_ready  = rst_n & w_ready;
  assign w_acc    = s_valid & s_ready;
  assign busy     = (r_state != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_ts        = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_ts        = 1'b1;
          w_state_nxt = s_last ? BOUND : ACC;
        end
      end
      ACC: begin
        if (w_acc && s_last) w_state_nxt = BOUND;
      end
      BOUND: begin
        // A real beat outranks flush; flush only closes a tile once spacing is met.
        if (w_acc) begin
          w_ts        = 1'b1;
          w_launch    = 1'b1;
          w_state_nxt = s_last ? BOUND : ACC;
        end else if (flush && !s_valid && w_spaced) begin
          w_ts        = 1'b1;
          w_launch    = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (res_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cyc   <= '0;
      r_fin   <= '0;
      r_tok   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ts)
        r_cyc <= '0;
      else if (!w_spaced)
        r_cyc <= r_cyc + 1'b1;
      r_fin <= {r_fin[L-2:0], w_ts};
      r_tok <= {r_tok[TW-2:0], w_launch};
    end
  end

  assign res_valid = r_tok[TW-1];

  // Lane k (row/column k+1) needs SIZE-k register stages.
  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    localparam int D = SIZE - k;
    logic [DATA_WIDTH-1:0] r_a [D];
    logic [DATA_WIDTH-1:0] r_b [D];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < D; s++) begin
          r_a[s] <= '0;
          r_b[s] <= '0;
        end
      end else begin
        r_a[0] <= w_acc ? s_a[k*DATA_WIDTH +: DATA_WIDTH] : '0;
        r_b[0] <= w_acc ? s_b[k*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s < D; s++) begin
          r_a[s] <= r_a[s-1];
          r_b[s] <= r_b[s-1];
        end
      end
    end

    assign in_left[k*DATA_WIDTH +: DATA_WIDTH] = r_a[D-1];
    assign in_up[k*DATA_WIDTH +: DATA_WIDTH]   = r_b[D-1];
  end

  for (genvar i = 1; i <= SIZE; i++) begin : g_fin_row
    for (genvar j = 1; j <= SIZE; j++) begin : g_fin_col
      assign finish[(i-1)*SIZE + j - 1] = r_fin[2*SIZE - i - j];
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder at SIZE=4, DATA_WIDTH=16 (L=7, token delay 8).
module tb_systolic_skew_feeder;
  localparam int DW = 16;
  localparam int SZ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid, s_ready, s_last, flush;
  logic [SZ*DW-1:0]  s_a, s_b, in_left, in_up;
  logic [SZ*SZ-1:0]  finish;
  logic              res_valid, busy;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int c      = 0;
  int t0;
  logic rv;
  int f15[$];
  int rq[$];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .SIZE(SZ)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_a(s_a), .s_b(s_b), .flush(flush), .in_left(in_left), .in_up(in_up),
    .finish(finish), .res_valid(res_valid), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] l1, l2, l3, l4);
    return {l4, l3, l2, l1};
  endfunction

  task automatic tick();
    @(negedge clk);
    c = c + 1;
  endtask

  task automatic drive(input logic v, input logic last, input logic [63:0] a, input logic [63:0] b, input logic f);
    s_valid = v;
    s_last  = last;
    s_a     = a;
    s_b     = b;
    flush   = f;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, '0, '0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, '0, '0, 0);
    tick();
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_left", in_left, 64'h0);
    chk("rst_fin", finish, 16'h0);
    chk("rst_res", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", s_ready, 1'b1);

    // Single beat with s_last from IDLE: skew and finish wave, no result token
    t0 = c;
    drive(1, 1, pk(16'h11, 16'h22, 16'h33, 16'h44), pk(16'h1, 16'h2, 16'h3, 16'h4), 0);
    tick();
    drive(0, 0, '0, '0, 0);
    chk("t1_left1", in_left, 64'h0044_0000_0000_0000);
    chk("t1_up1", in_up, 64'h0004_0000_0000_0000);
    chk("t1_fin1", finish, 16'h8000);
    chk("t1_ready1", s_ready, 1'b0);
    chk("t1_busy1", busy, 1'b1);
    tick();
    chk("t1_left2", in_left, 64'h0000_0033_0000_0000);
    chk("t1_fin2", finish, 16'h4800);
    tick();
    chk("t1_left3", in_left, 64'h0000_0000_0022_0000);
    chk("t1_fin3", finish, 16'h2480);
    tick();
    chk("t1_left4", in_left, 64'h0000_0000_0000_0011);
    chk("t1_up4", in_up, 64'h0000_0000_0000_0001);
    tick();
    chk("t1_fin5_pe22", finish[5], 1'b1);
    chk("t1_fin5", finish, 16'h0124);
    chk("t1_left5", in_left, 64'h0);
    tick();
    tick();
    chk("t1_fin7", finish, 16'h0001);
    chk("t1_ready7", s_ready, 1'b1);
    rv = 1'b0;
    repeat (12) begin
      rv = rv | res_valid;
      tick();
    end
    chk("t1_no_res", rv, 1'b0);

    // Two-beat tile then continuous valid: spacing and result timing
    do_reset();
    t0 = c;
    drive(1, 0, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 0);
    chk("t2_ready0", s_ready, 1'b1);
    tick();
    drive(1, 1, pk(2, 2, 2, 2), pk(2, 2, 2, 2), 0);
    chk("t2_ready1", s_ready, 1'b1);
    tick();
    drive(1, 0, pk(3, 3, 3, 3), pk(3, 3, 3, 3), 0);
    while (c < t0 + 7) begin
      chk("t2_ready_low", s_ready, 1'b0);
      tick();
    end
    chk("t2_ready7", s_ready, 1'b1);
    tick();
    chk("t2_fin8", finish, 16'h8000);
    while (c <= t0 + 20) begin
      chk("t2_res", res_valid, (c == t0 + 15));
      tick();
    end
    drive(0, 0, '0, '0, 0);

    // Seven-beat tile closed by flush
    do_reset();
    t0 = c;
    for (int k = 0; k < 7; k++) begin
      drive(1, (k == 6), pk(16'(k+1), 16'(k+1), 16'(k+1), 16'(k+1)), pk(16'(k+1), 16'(k+1), 16'(k+1), 16'(k+1)), 0);
      chk("t3_ready_beat", s_ready, 1'b1);
      tick();
    end
    drive(0, 0, '0, '0, 1);
    chk("t3_bound_ready", s_ready, 1'b1);
    tick();
    drive(0, 0, '0, '0, 0);
    chk("t3_fin_inject", finish, 16'h8000);
    chk("t3_zero_lane4", in_left[63:48], 16'h0);
    chk("t3_drain_ready", s_ready, 1'b0);
    while (c <= t0 + 16) begin
      chk("t3_res", res_valid, (c == t0 + 15));
      chk("t3_busy", busy, (c <= t0 + 15));
      tick();
    end
    chk("t3_idle_ready", s_ready, 1'b1);
    drive(1, 1, pk(7, 7, 7, 7), pk(7, 7, 7, 7), 0);
    tick();
    drive(0, 0, '0, '0, 0);
    rv = 1'b0;
    repeat (20) begin
      rv = rv | res_valid;
      tick();
    end
    chk("t3_no_res_after_idle", rv, 1'b0);

    // flush together with s_valid in BOUND: data wins
    do_reset();
    t0 = c;
    drive(1, 1, pk(9, 9, 9, 9), pk(9, 9, 9, 9), 0);
    tick();
    drive(0, 0, '0, '0, 0);
    while (c < t0 + 7) tick();
    drive(1, 0, pk(5, 6, 7, 8), pk(5, 6, 7, 8), 1);
    chk("t4_ready", s_ready, 1'b1);
    tick();
    drive(0, 0, '0, '0, 0);
    chk("t4_data_lane4", in_left[63:48], 16'h0008);
    chk("t4_acc_ready", s_ready, 1'b1);
    chk("t4_busy", busy, 1'b1);
    while (c < t0 + 15) tick();
    chk("t4_res", res_valid, 1'b1);
    tick();
    chk("t4_res_end", res_valid, 1'b0);

    // Reset mid-ACC with a result token in flight
    do_reset();
    t0 = c;
    drive(1, 1, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 0);
    tick();
    drive(0, 0, '0, '0, 0);
    while (c < t0 + 7) tick();
    drive(1, 0, pk(16'hA, 16'hA, 16'hA, 16'hA), pk(16'hA, 16'hA, 16'hA, 16'hA), 0);
    chk("t5_ready", s_ready, 1'b1);
    tick();
    drive(1, 0, pk(16'hB, 16'hB, 16'hB, 16'hB), pk(16'hB, 16'hB, 16'hB, 16'hB), 0);
    tick();
    drive(0, 0, '0, '0, 0);
    chk("t5_pre_lane4", in_left[63:48], 16'h000B);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_left", in_left, 64'h0);
    chk("t5_rst_up", in_up, 64'h0);
    chk("t5_rst_fin", finish, 16'h0);
    chk("t5_rst_res", res_valid, 1'b0);
    chk("t5_rst_ready", s_ready, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (2*SZ + 2) begin
      tick();
      chk("t5_post_ready", s_ready, 1'b1);
      chk("t5_post_res", res_valid, 1'b0);
      chk("t5_post_busy", busy, 1'b0);
    end

    // Back-to-back 7-beat tiles with valid always high
    do_reset();
    t0 = c;
    for (int k = 0; k < 28; k++) begin
      if (k < 21) begin
        drive(1, (k % 7 == 6), pk(16'(k), 16'(k), 16'(k), 16'(k)), pk(16'(k), 16'(k), 16'(k), 16'(k)), 0);
        chk("t6_ready", s_ready, 1'b1);
      end else begin
        drive(0, 0, '0, '0, 0);
      end
      if (finish[15]) f15.push_back(c - t0);
      if (res_valid) rq.push_back(c - t0);
      tick();
    end
    chk("t6_wave_count", f15.size(), 3);
    for (int i = 0; i < f15.size(); i++)
      chk("t6_wave_time", f15[i], 7*i + 1);
    chk("t6_res_count", rq.size(), 2);
    for (int i = 0; i < rq.size(); i++)
      chk("t6_res_time", rq[i], 7*i + 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the SIZE x SIZE output-stationary PE kernel; drives its in_left, in_up and per-PE finish buses.
- Accepts one operand beat per cycle (A column vector, B row vector) over valid/ready and applies the diagonal skew the array needs.
- Generates the diagonal finish wave at each tile boundary, enforces minimum tile spacing and flushes the last tile.
- Flags the single cycle in which the kernel's out_matrix holds one complete tile result.

Parameters:
DATA_WIDTH, 16, operand lane width
SIZE, 8, array dimension; minimum tile period L = 2*SIZE-1 cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  operand beat valid
s_ready  out  1  beat accepted on (s_valid & s_ready) at posedge
s_last  in  1  beat is the last of its tile
s_a  in  SIZE*DATA_WIDTH  A column; lane i = [i*DATA_WIDTH-1 -: DATA_WIDTH], feeds row i
s_b  in  SIZE*DATA_WIDTH  B row; lane j feeds column j
flush  in  1  close out the pending tile without new data
in_left  out  SIZE*DATA_WIDTH  to kernel in_left
in_up  out  SIZE*DATA_WIDTH  to kernel in_up
finish  out  SIZE*SIZE  to kernel finish; bit (i-1)*SIZE+j-1 drives PE(i,j)
res_valid  out  1  out_matrix holds a complete tile result this cycle
busy  out  1  state != IDLE

Behaviour:
- PE indexing: PE(i,j), i,j in 1..SIZE, with i=SIZE the top row and j=SIZE the left column. Row hops r=SIZE-i, column hops c=SIZE-j.
- Every cycle, lane stage 0 loads either the accepted beat or zeros (a bubble). Zero products add nothing, so bubbles are harmless.
- Skew, for a beat accepted at the edge ending cycle t:
  - in_left lane i shows s_a lane i during cycle t+1+(SIZE-i).
  - in_up lane j shows s_b lane j during cycle t+1+(SIZE-j).
  - Implement as per-lane register chains of depth 1..SIZE.
- Tile-start beat: the first accepted beat in IDLE, the first accepted beat after an s_last, or an injected flush beat.
- Finish wave: for a tile-start beat at t, finish bit of PE(i,j) is high only in cycle t+1+r+c. Use a one-hot shift register of depth L indexed by r+c. Several waves may be in flight at once.
- Spacing counter cyc: cycles since last tile-start, saturating at L-1, cleared by each tile-start. A tile-start may be accepted only when cyc == L-1.
- States:
  - IDLE: s_ready=1, no open tile. Accept -> tile-start; go ACC, or BOUND if s_last is also set.
  - ACC: s_ready=1. s_valid low injects a bubble. Accepting s_last goes to BOUND.
  - BOUND: previous tile closed, result not yet latched. s_ready = (cyc == L-1); bubbles injected while low.
    - Accepted beat -> tile-start; launches a result token; go ACC, or stay BOUND if s_last is set.
    - flush=1 with s_valid=0 and cyc == L-1 -> inject a zero tile-start beat, launch a token, go DRAIN.
    - s_valid has priority over flush. flush is ignored in every other state or cycle.
  - DRAIN: s_ready=0, zeros injected. Go IDLE in the cycle res_valid is high.
- Result token: a shift register of depth 2*SIZE. A token launched by a tile-start at t raises res_valid for exactly cycle t+2*SIZE.
  - In that cycle PE(1,1) has just latched, and no PE has yet latched the next tile (spacing >= L).
  - A tile-start accepted from IDLE launches no token.
- Reset (async assert, release synchronised by the register flops):
  - All skew registers, in_left, in_up, finish, res_valid, the token and finish shift registers and cyc clear to 0.
  - State returns to IDLE; s_ready=0 while rst_n=0.
  - Reset mid-tile abandons the tile; no res_valid for it.
- busy is high in ACC, BOUND and DRAIN.

Test Plan:
- SIZE=4, DW=16, IDLE. Accept one beat at t with s_a lanes = 0x0011,0x0022,0x0033,0x0044 (lane1..4) and s_last=1. Required:
  - in_left lane4 = 0x0044 in t+1, lane1 = 0x0011 in t+4, all other cycles zero.
  - finish bit 15 high in t+1, bit 0 high in t+7, bit 5 (PE(2,2)) high in t+5.
  - res_valid stays 0.
- SIZE=4, tile A of K=2 beats from IDLE (start t0), then s_valid held high continuously. Required:
  - s_ready low t0+2..t0+6.
  - Next tile-start accepted at t0+7.
  - res_valid high only in t0+15.
- Tile of 7 beats then s_valid=0 and flush=1 at cycle t0+7, where t0 is the tile-start cycle. Required:
  - Zero tile-start injected at t0+7.
  - res_valid in t0+15.
  - busy low from t0+16; next tile-start gives no res_valid.
- BOUND with cyc == L-1, flush=1 and s_valid=1 in the same cycle. Required: the data beat becomes the tile-start, no flush, state ACC.
- rst_n pulled low mid-ACC. Required: outputs zero immediately; after release, IDLE with s_ready=1 and no res_valid for 2*SIZE cycles.
- Back-to-back 7-beat tiles, s_valid always high. Required: s_ready never drops, and finish waves are exactly 7 cycles apart.
